// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_CPU,
        GRANT_AUX,
        RELEASE
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_CPU_SRC,
        GRANT_AUX_SRC
    } grant_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Grant-state watchdog: counts cycles since the grant and flags expiry at TIMEOUT_CYCLES.
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_count;

    assign o_expired = (r_count == W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// CPU-priority arbiter for one wishbone-manager port, with an aux starvation cap and timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic        aux_read,
    input  logic        aux_write,
    input  logic [31:0] aux_address,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_sel,
    output logic [31:0] aux_rdata,
    output logic        aux_ack,
    output logic        aux_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sel,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned SW = $clog2(MAX_CPU_STREAK + 1);

    arb_state_t  r_state, w_next;
    grant_t      w_grant;
    logic [SW-1:0] r_streak;
    logic        r_mem_read, r_mem_write;
    logic [31:0] r_mem_address, r_mem_wdata;
    logic [3:0]  r_mem_sel;
    logic        w_cpu_pend, w_aux_pend, w_in_grant, w_expired, w_done;

    assign w_cpu_pend = cpu_read | cpu_write;
    assign w_aux_pend = aux_read | aux_write;
    assign w_in_grant = (r_state == GRANT_CPU) || (r_state == GRANT_AUX);
    assign w_done     = w_in_grant && (mem_ack || w_expired);

    arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_grant != GRANT_NONE),
        .i_enable  (w_in_grant),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = GRANT_NONE;
        case (r_state)
            IDLE: begin
                if (w_aux_pend && (r_streak == SW'(MAX_CPU_STREAK))) begin
                    w_grant = GRANT_AUX_SRC;
                    w_next  = GRANT_AUX;
                end else if (w_cpu_pend) begin
                    w_grant = GRANT_CPU_SRC;
                    w_next  = GRANT_CPU;
                end else if (w_aux_pend) begin
                    w_grant = GRANT_AUX_SRC;
                    w_next  = GRANT_AUX;
                end
            end
            GRANT_CPU, GRANT_AUX: begin
                if (w_done) w_next = RELEASE;
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Write takes precedence when a requester asserts both read and write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_sel     <= '0;
        end else if (w_grant == GRANT_CPU_SRC) begin
            r_mem_read    <= cpu_read & ~cpu_write;
            r_mem_write   <= cpu_write;
            r_mem_address <= cpu_address;
            r_mem_wdata   <= cpu_wdata;
            r_mem_sel     <= cpu_sel;
        end else if (w_grant == GRANT_AUX_SRC) begin
            r_mem_read    <= aux_read & ~aux_write;
            r_mem_write   <= aux_write;
            r_mem_address <= aux_address;
            r_mem_wdata   <= aux_wdata;
            r_mem_sel     <= aux_sel;
        end else if (w_done) begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_sel     <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_grant == GRANT_CPU_SRC) begin
            if (!w_aux_pend)                           r_streak <= '0;
            else if (r_streak != SW'(MAX_CPU_STREAK))  r_streak <= r_streak + 1'b1;
        end else if (w_grant == GRANT_AUX_SRC) begin
            r_streak <= '0;
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_sel     = r_mem_sel;

    // mem_ack beats a coincident timeout: real data, no error.
    assign cpu_ack   = (r_state == GRANT_CPU) && w_done;
    assign aux_ack   = (r_state == GRANT_AUX) && w_done;
    assign cpu_err   = cpu_ack && !mem_ack;
    assign aux_err   = aux_ack && !mem_ack;
    assign cpu_rdata = !cpu_ack ? '0 : (mem_ack ? mem_rdata : TIMEOUT_DATA);
    assign aux_rdata = !aux_ack ? '0 : (mem_ack ? mem_rdata : TIMEOUT_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single/contended grants, streak cap, write priority, timeout, reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_address, cpu_wdata;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_err;
    logic        aux_read, aux_write;
    logic [31:0] aux_address, aux_wdata;
    logic [3:0]  aux_sel;
    logic [31:0] aux_rdata;
    logic        aux_ack, aux_err;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_CPU_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .aux_read(aux_read), .aux_write(aux_write), .aux_address(aux_address),
        .aux_wdata(aux_wdata), .aux_sel(aux_sel), .aux_rdata(aux_rdata),
        .aux_ack(aux_ack), .aux_err(aux_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_read || mem_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit exp_cpu;
        rst = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0; cpu_sel = '0;
        aux_read = 0; aux_write = 0; aux_address = '0; aux_wdata = '0; aux_sel = '0;
        mem_rdata = '0; mem_ack = 0;
        #2;
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_acks", {30'b0, cpu_ack, aux_ack}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single CPU read, ack 3 cycles after mem_read appears
        cpu_read = 1; cpu_address = 32'h0000_0100;
        #1 chk("t1_pre_grant", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t1_mem_read", {31'b0, mem_read}, 32'd1);
        chk("t1_mem_address", mem_address, 32'h0000_0100);
        chk("t1_mem_write", {31'b0, mem_write}, 32'd0);
        tick(); tick(); tick();
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk("t1_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h1234_5678);
        chk("t1_cpu_err", {31'b0, cpu_err}, 32'd0);
        chk("t1_aux_ack", {31'b0, aux_ack}, 32'd0);
        tick();
        mem_ack = 0; cpu_read = 0;
        #1;
        chk("t1_release_ack", {31'b0, cpu_ack}, 32'd0);
        chk("t1_release_mem", {31'b0, mem_read}, 32'd0);
        tick();

        // simultaneous requests: CPU first, then aux
        cpu_read = 1; cpu_address = 32'h0000_0A00;
        aux_read = 1; aux_address = 32'h0000_0B00;
        tick();
        chk("t2_first_addr", mem_address, 32'h0000_0A00);
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        #1;
        chk("t2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        chk("t2_aux_ack_off", {31'b0, aux_ack}, 32'd0);
        chk("t2_aux_rdata_off", aux_rdata, 32'd0);
        tick();
        mem_ack = 0; cpu_read = 0;
        #1 chk("t2_release", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t2_idle", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t2_second_addr", mem_address, 32'h0000_0B00);
        mem_ack = 1; mem_rdata = 32'h3333_4444;
        #1;
        chk("t2_aux_ack", {31'b0, aux_ack}, 32'd1);
        chk("t2_aux_rdata", aux_rdata, 32'h3333_4444);
        chk("t2_cpu_ack_off", {31'b0, cpu_ack}, 32'd0);
        tick();
        mem_ack = 0; aux_read = 0;
        tick();

        // continuous contention: C C C C A repeating
        cpu_read = 1; cpu_address = 32'h0000_0200;
        aux_read = 1; aux_address = 32'h0000_0300;
        for (int k = 0; k < 10; k++) begin
            exp_cpu = ((k % 5) != 4);
            wait_grant(ok);
            chk("t3_grant_seen", {31'b0, ok}, 32'd1);
            chk("t3_order_addr", mem_address, exp_cpu ? 32'h0000_0200 : 32'h0000_0300);
            mem_ack = 1; mem_rdata = 32'(k);
            #1;
            chk("t3_cpu_ack", {31'b0, cpu_ack}, {31'b0, exp_cpu});
            chk("t3_aux_ack", {31'b0, aux_ack}, {31'b0, ~exp_cpu});
            tick();
            mem_ack = 0;
        end
        cpu_read = 0; aux_read = 0;
        tick(); tick();

        // read+write together is a write
        cpu_read = 1; cpu_write = 1; cpu_address = 32'h0000_0400;
        cpu_wdata = 32'hCAFE_F00D; cpu_sel = 4'b0011;
        tick();
        chk("t4_mem_write", {31'b0, mem_write}, 32'd1);
        chk("t4_mem_read", {31'b0, mem_read}, 32'd0);
        chk("t4_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("t4_mem_sel", {28'b0, mem_sel}, 32'h3);
        mem_ack = 1;
        #1 chk("t4_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        tick();
        mem_ack = 0; cpu_read = 0; cpu_write = 0;
        tick();

        // aux timeout with no mem_ack
        aux_read = 1; aux_address = 32'h0000_0500;
        tick();
        chk("t5_mem_read", {31'b0, mem_read}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_early_ack", {31'b0, aux_ack}, 32'd0);
            tick();
        end
        chk("t5_aux_ack", {31'b0, aux_ack}, 32'd1);
        chk("t5_aux_err", {31'b0, aux_err}, 32'd1);
        chk("t5_aux_rdata", aux_rdata, 32'hDEAD_BEEF);
        chk("t5_cpu_ack_off", {31'b0, cpu_ack}, 32'd0);
        tick();
        chk("t5_release", {31'b0, mem_read}, 32'd0);
        chk("t5_ack_once", {31'b0, aux_ack}, 32'd0);
        aux_read = 0;
        tick();

        // mem_ack coincident with timeout: no error
        aux_read = 1; aux_address = 32'h0000_0510;
        tick();
        for (int i = 0; i < 8; i++) tick();
        mem_ack = 1; mem_rdata = 32'h55AA_0011;
        #1;
        chk("t5b_aux_ack", {31'b0, aux_ack}, 32'd1);
        chk("t5b_aux_err", {31'b0, aux_err}, 32'd0);
        chk("t5b_aux_rdata", aux_rdata, 32'h55AA_0011);
        tick();
        mem_ack = 0; aux_read = 0;
        tick();

        // stray mem_ack in IDLE
        mem_ack = 1;
        #1 chk("t6_stray_ack", {30'b0, cpu_ack, aux_ack}, 32'd0);
        tick();
        mem_ack = 0;
        chk("t6_stray_no_grant", {31'b0, mem_read}, 32'd0);

        // reset two cycles into a CPU grant
        cpu_read = 1; cpu_address = 32'h0000_0600;
        tick();
        chk("t6_grant", {31'b0, mem_read}, 32'd1);
        tick(); tick();
        rst = 1;
        #1;
        chk("t6_rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("t6_rst_mem_address", mem_address, 32'd0);
        chk("t6_rst_no_ack", {31'b0, cpu_ack}, 32'd0);
        tick(); tick();
        rst = 0;
        #1 chk("t6_post_rst_idle", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t6_regrant", {31'b0, mem_read}, 32'd1);
        chk("t6_regrant_addr", mem_address, 32'h0000_0600);
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        #1 chk("t6_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        tick();
        mem_ack = 0; cpu_read = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
